// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, SPI mode struct and counter-width helpers for the SPI master
package spi_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_e;
   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;
   function automatic int bit_cnt_w(input int data_w);
      return $clog2(2 * data_w + 1);
   endfunction
   function automatic int div_cnt_w(input int clk_div);
      return $clog2(clk_div + 1);
   endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: CLK_DIV divider producing leading/trailing edge strobes and an SCLK idling at CPOL
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic shift_en,
   input  logic cpol,
   output logic tick,
   output logic lead_stb,
   output logic trail_stb,
   output logic sclk
);
   localparam int DIV_W = div_cnt_w(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   logic [DIV_W-1:0] cnt;
   logic             ph;
   assign tick      = run && cnt == DIV_LAST;
   assign lead_stb  = tick && shift_en && !ph;
   assign trail_stb = tick && shift_en && ph;
   // ph is 1 while SCLK sits at its active (non-CPOL) level
   assign sclk      = cpol ^ ph;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         ph  <= 1'b0;
      end else begin
         cnt <= (!run || tick) ? '0 : cnt + 1'b1;
         ph  <= run && (ph ^ (lead_stb || trail_stb));
      end
   end
endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: parametrised SPI master with multi-slave select, run-time CPOL/CPHA and SCLK divider
// Define SPI_LOOPBACK_EN to add the loopback port (receive path samples MOSI instead of MISO).
module spi_master_cfg
   import spi_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int NUM_SS  = 4,
   parameter  int CLK_DIV = 2,
   localparam int SS_W    = NUM_SS > 1 ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SS_W-1:0]   ss_sel,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] data_in,
`ifdef SPI_LOOPBACK_EN
   input  logic              loopback,
`endif
   input  logic              MISO,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              done,
   output logic              sclk,
   output logic              MOSI,
   output logic [NUM_SS-1:0] ss_n
);
   localparam int BC_W = bit_cnt_w(DATA_W);
   localparam logic [BC_W-1:0] LAST_EDGE = BC_W'(2 * DATA_W - 1);
   spi_state_e        state, state_nx;
   spi_mode_t         mode_r;
   logic [SS_W-1:0]   ss_r;
   logic [DATA_W-1:0] tx, rx;
   logic [BC_W-1:0]   edge_cnt;
   logic accept, tick, lead_stb, trail_stb, last_edge, shift_ev, sample_ev, hold_end, rx_bit;
   assign accept    = state == IDLE && start && int'(ss_sel) < NUM_SS;
   assign last_edge = edge_cnt == LAST_EDGE;
   assign hold_end  = state == HOLD && tick;
   // The final trailing edge never shifts, so MOSI keeps the LSB after SHIFT
   assign shift_ev  = mode_r.cpha ? lead_stb : trail_stb && !last_edge;
   assign sample_ev = mode_r.cpha ? trail_stb : lead_stb;
   assign busy      = state != IDLE;
   assign ss_n      = busy ? ~(NUM_SS'(1) << ss_r) : '1;
`ifdef SPI_LOOPBACK_EN
   logic lb_r;
   assign rx_bit = lb_r ? MOSI : MISO;
`else
   assign rx_bit = MISO;
`endif
   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (busy),
      .shift_en  (state == SHIFT),
      .cpol      (mode_r.cpol),
      .tick      (tick),
      .lead_stb  (lead_stb),
      .trail_stb (trail_stb),
      .sclk      (sclk)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? SETUP : IDLE;
         SETUP:   state_nx = tick ? SHIFT : SETUP;
         SHIFT:   state_nx = (tick && last_edge) ? HOLD : SHIFT;
         HOLD:    state_nx = tick ? IDLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r   <= '0;
         ss_r     <= '0;
         tx       <= '0;
         rx       <= '0;
         edge_cnt <= '0;
         MOSI     <= 1'b0;
         data_out <= '0;
         done     <= 1'b0;
`ifdef SPI_LOOPBACK_EN
         lb_r     <= 1'b0;
`endif
      end else begin
         done <= hold_end;
         if (accept) begin
            mode_r   <= spi_mode_t'(mode);
            ss_r     <= ss_sel;
            // CPHA=0 presents the MSB during SETUP, so the register starts one bit ahead
            tx       <= mode[0] ? data_in : data_in << 1;
            MOSI     <= data_in[DATA_W-1];
            rx       <= '0;
            edge_cnt <= '0;
`ifdef SPI_LOOPBACK_EN
            lb_r     <= loopback;
`endif
         end else begin
            if (shift_ev) begin
               MOSI <= tx[DATA_W-1];
               tx   <= tx << 1;
            end
            if (sample_ev) rx <= {rx[DATA_W-2:0], rx_bit};
            if (lead_stb || trail_stb) edge_cnt <= edge_cnt + 1'b1;
            if (hold_end) data_out <= rx;
         end
      end
   end
endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: randomized self-checking bench with a behavioural SPI slave and timing model
module tb_spi_master_cfg;
   localparam int DW  = 8;
   localparam int DIV = 2;
   localparam int LAT = 1 + DIV * (2 * DW + 2);
   logic clk = 0, rst_n = 0, start = 0, start3 = 0, MISO = 0;
   logic [1:0] ss_sel = 0, ss_sel3 = 0, mode = 0;
   logic [DW-1:0] data_in = 0;
`ifdef SPI_LOOPBACK_EN
   logic loopback = 0;
`endif
   logic [DW-1:0] data_out, data_out3;
   logic busy, done, sclk, MOSI, busy3, done3, sclk3, MOSI3;
   logic [3:0] ss_n;
   logic [2:0] ss_n3;
   int n_checks = 0, n_fail = 0;
   logic [DW-1:0] s_word = 0, s_cap = 0;
   int s_idx = 0, s_edges = 0;
   logic s_cpol = 0, s_cpha = 0, s_prev_sel = 0, s_prev_sclk = 0;

   always #5 clk = ~clk;

   spi_master_cfg #(.DATA_W(DW), .NUM_SS(4), .CLK_DIV(DIV)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ss_sel(ss_sel), .mode(mode), .data_in(data_in),
`ifdef SPI_LOOPBACK_EN
      .loopback(loopback),
`endif
      .MISO(MISO), .data_out(data_out), .busy(busy), .done(done), .sclk(sclk), .MOSI(MOSI), .ss_n(ss_n)
   );

   spi_master_cfg #(.DATA_W(DW), .NUM_SS(3), .CLK_DIV(DIV)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .ss_sel(ss_sel3), .mode(mode), .data_in(data_in),
`ifdef SPI_LOOPBACK_EN
      .loopback(loopback),
`endif
      .MISO(MISO), .data_out(data_out3), .busy(busy3), .done(done3), .sclk(sclk3), .MOSI(MOSI3), .ss_n(ss_n3)
   );

   // Slave: captures MOSI on its capture edge and presents s_word MSB first per CPOL/CPHA
   initial forever begin
      @(negedge clk);
      if (ss_n != 4'hF) begin
         if (!s_prev_sel) begin
            s_idx = DW - 1;
            s_cap = 0;
            s_edges = 0;
            if (!s_cpha) MISO = s_word[DW-1];
         end else if (sclk !== s_prev_sclk) begin
            s_edges++;
            if ((sclk !== s_cpol) != s_cpha) s_cap = {s_cap[DW-2:0], MOSI};
            else if (s_cpha) begin
               if (s_idx >= 0) MISO = s_word[s_idx];
               s_idx--;
            end else begin
               s_idx--;
               if (s_idx >= 0) MISO = s_word[s_idx];
            end
         end
      end
      s_prev_sel = (ss_n != 4'hF);
      s_prev_sclk = sclk;
   end

   task automatic launch(input logic [DW-1:0] din, input logic [DW-1:0] slv, input logic [1:0] md, input logic [1:0] ss);
      data_in = din;
      mode = md;
      ss_sel = ss;
      s_word = slv;
      s_cpol = md[1];
      s_cpha = md[0];
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(input int k0, output int lat, output int nbusy, output logic [3:0] pat,
                            output logic bad, output logic [DW-1:0] dout, output logic sclk_end);
      int k = k0;
      logic [DW-1:0] d0 = data_out;
      lat = -1;
      nbusy = 0;
      bad = 0;
      pat = ss_n;
      while (k < 200) begin
         if (done) begin
            lat = k;
            if (ss_n !== 4'hF || busy) bad = 1;
            break;
         end
         if (busy) nbusy++;
         else bad = 1;
         if (ss_n !== pat || data_out !== d0 || $isunknown(MOSI)) bad = 1;
         @(negedge clk);
         k++;
      end
      dout = data_out;
      sclk_end = sclk;
   endtask

   task automatic run_and_check_xfer(input logic [DW-1:0] din, input logic [DW-1:0] slv, input logic [1:0] md, input logic [1:0] ss);
      int lat, nb;
      logic [3:0] pat, exp_pat;
      logic bad, se;
      logic [DW-1:0] dout;
      exp_pat = ~(4'b0001 << ss);
      launch(din, slv, md, ss);
      n_checks++;
      if (sclk !== md[1] || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL xfer_first_cycle md=%0d: sclk=%b busy=%b, expected sclk=%b busy=1", md, sclk, busy, md[1]);
      end
      wait_done(1, lat, nb, pat, bad, dout, se);
      n_checks++;
      if (lat !== LAT) begin n_fail++; $display("FAIL xfer_latency md=%0d: got %0d expected %0d", md, lat, LAT); end
      n_checks++;
      if (nb !== LAT - 1) begin n_fail++; $display("FAIL xfer_busy_cycles md=%0d: got %0d expected %0d", md, nb, LAT - 1); end
      n_checks++;
      if (pat !== exp_pat || bad !== 1'b0) begin
         n_fail++;
         $display("FAIL xfer_ss_n md=%0d: got %b (glitch=%b) expected %b", md, pat, bad, exp_pat);
      end
      n_checks++;
      if (dout !== slv) begin n_fail++; $display("FAIL xfer_data_out md=%0d: got %h expected %h", md, dout, slv); end
      n_checks++;
      if (s_cap !== din) begin n_fail++; $display("FAIL xfer_mosi md=%0d: slave got %h expected %h", md, s_cap, din); end
      n_checks++;
      if (s_edges !== 2 * DW || se !== md[1]) begin
         n_fail++;
         $display("FAIL xfer_sclk md=%0d: edges=%0d end=%b expected edges=%0d end=%b", md, s_edges, se, 2 * DW, md[1]);
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      n_checks++;
      if (busy !== 0 || done !== 0 || data_out !== 0 || ss_n !== 4'hF || sclk !== 0 || MOSI !== 0) begin
         n_fail++;
         $display("FAIL reset: busy=%b done=%b data_out=%h ss_n=%b sclk=%b MOSI=%b expected 0 0 00 1111 0 0",
                  busy, done, data_out, ss_n, sclk, MOSI);
      end
   endtask

   task automatic test_modes;
      for (int m = 0; m < 4; m++) run_and_check_xfer(8'hA5, 8'h3C, 2'(m), 2'd1);
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++)
         run_and_check_xfer(DW'($urandom), DW'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
   endtask

   task automatic test_back_to_back;
      int lat, nb;
      logic [3:0] pat;
      logic bad, se;
      logic [DW-1:0] dout;
      launch(8'hA5, 8'h3C, 2'b00, 2'd1);
      wait_done(1, lat, nb, pat, bad, dout, se);
      n_checks++;
      if (lat !== LAT || dout !== 8'h3C) begin
         n_fail++;
         $display("FAIL b2b_first: lat=%0d data_out=%h expected %0d 3c", lat, dout, LAT);
      end
      launch(8'h0F, 8'hC3, 2'b00, 2'd2);
      n_checks++;
      if (ss_n !== 4'b1011 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_gap: ss_n=%b busy=%b expected 1011 1", ss_n, busy);
      end
      wait_done(1, lat, nb, pat, bad, dout, se);
      n_checks++;
      if (lat !== LAT || dout !== 8'hC3 || s_cap !== 8'h0F || bad !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second: lat=%0d data_out=%h mosi=%h bad=%b expected %0d c3 0f 0", lat, dout, s_cap, bad, LAT);
      end
      @(negedge clk);
   endtask

   task automatic test_busy_ignore;
      int lat, nb, extra;
      logic [3:0] pat;
      logic bad, se;
      logic [DW-1:0] dout;
      launch(8'h5A, 8'h81, 2'b01, 2'd3);
      repeat (4) @(negedge clk);
      start = 1;
      data_in = 8'hFF;
      ss_sel = 0;
      mode = 2'b10;
      @(negedge clk);
      start = 0;
      wait_done(6, lat, nb, pat, bad, dout, se);
      n_checks++;
      if (lat !== LAT || dout !== 8'h81 || s_cap !== 8'h5A) begin
         n_fail++;
         $display("FAIL busy_ignore_xfer: lat=%0d data_out=%h mosi=%h expected %0d 81 5a", lat, dout, s_cap, LAT);
      end
      n_checks++;
      if (pat !== 4'b0111 || bad !== 1'b0 || se !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_ignore_pins: ss_n=%b bad=%b sclk=%b expected 0111 0 0", pat, bad, se);
      end
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy || done) extra++;
      end
      n_checks++;
      if (extra !== 0) begin n_fail++; $display("FAIL busy_ignore_queue: %0d active cycles, expected 0", extra); end
   endtask

   task automatic test_invalid;
      int act = 0;
      start3 = 1;
      ss_sel3 = 2'd3;
      @(negedge clk);
      start3 = 0;
      repeat (50) begin
         if (busy3 || done3 || ss_n3 !== 3'b111 || sclk3 !== 0 || MOSI3 !== 0 || data_out3 !== 0) act++;
         @(negedge clk);
      end
      n_checks++;
      if (act !== 0) begin n_fail++; $display("FAIL invalid_ss: %0d cycles with activity, expected 0", act); end
      start3 = 1;
      ss_sel3 = 2'd2;
      @(negedge clk);
      start3 = 0;
      n_checks++;
      if (busy3 !== 1'b1 || ss_n3 !== 3'b011) begin
         n_fail++;
         $display("FAIL valid_ss3: busy=%b ss_n=%b expected 1 011", busy3, ss_n3);
      end
      repeat (LAT + 2) @(negedge clk);
   endtask

   task automatic test_loopback;
      int lat, nb;
      logic [3:0] pat;
      logic bad, se;
      logic [DW-1:0] dout, din, exp;
      for (int i = 0; i < 2; i++) begin
         din = i == 0 ? 8'h96 : DW'($urandom);
`ifdef SPI_LOOPBACK_EN
         loopback = 1;
         exp = din;
`else
         exp = '0;
`endif
         launch(din, 8'h00, i == 0 ? 2'b00 : 2'b11, 2'd0);
`ifdef SPI_LOOPBACK_EN
         loopback = 0;
`endif
         wait_done(1, lat, nb, pat, bad, dout, se);
         n_checks++;
         if (dout !== exp || lat !== LAT) begin
            n_fail++;
            $display("FAIL loopback%0d: data_out=%h lat=%0d expected %h %0d", i, dout, lat, exp, LAT);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid;
      int act = 0;
      launch(8'hC3, 8'h5A, 2'b10, 2'd2);
      repeat (18) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || sclk === 1'bx) begin n_fail++; $display("FAIL reset_mid_pre: busy=%b expected 1", busy); end
      rst_n = 0;
      #1;
      n_checks++;
      if (busy !== 0 || done !== 0 || ss_n !== 4'hF || sclk !== 0 || data_out !== 0 || MOSI !== 0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b done=%b ss_n=%b sclk=%b data_out=%h MOSI=%b expected 0 0 1111 0 00 0",
                  busy, done, ss_n, sclk, data_out, MOSI);
      end
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (50) begin
         @(negedge clk);
         if (busy || done || data_out !== 0 || ss_n !== 4'hF) act++;
      end
      n_checks++;
      if (act !== 0) begin n_fail++; $display("FAIL reset_mid_after: %0d active cycles, expected 0", act); end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      test_reset();
      test_modes();
      test_random();
      test_back_to_back();
      test_busy_ignore();
      test_invalid();
      test_loopback();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
